// File: rtl/pdp8_pkg.sv
// Shared PDP-8 definitions: word/address widths plus the memory arbiter's
// state/client encodings and its grant-selection helper.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

package pdp8_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    CL_IFU  = 2'd0,
    CL_EXRD = 2'd1,
    CL_EXWR = 2'd2
  } arb_client_e;

  localparam int ARB_STARVE_LIMIT_DEF = 8;
  localparam int ARB_RD_LATENCY_DEF   = 1;

  // exec_wr > exec_rd > ifu, unless fetch has lost too many times in a row.
  function automatic arb_client_e arb_pick(input logic wr_req,
                                           input logic rd_req,
                                           input logic ifu_req,
                                           input logic ifu_starved);
    arb_client_e win;
    if (ifu_req && ifu_starved) begin
      win = CL_IFU;
    end else if (wr_req) begin
      win = CL_EXWR;
    end else if (rd_req) begin
      win = CL_EXRD;
    end else begin
      win = CL_IFU;
    end
    return win;
  endfunction

endpackage

// File: rtl/pdp_mem_arbiter.sv
// Single-port memory arbiter merging fetch read, execution read and execution
// write onto one synchronous memory with a fixed read latency.
module pdp_mem_arbiter
  import pdp8_pkg::*;
#(
  parameter int RD_LATENCY   = ARB_RD_LATENCY_DEF,
  parameter int STARVE_LIMIT = ARB_STARVE_LIMIT_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ifu_rd_req,
  input  logic [`ADDR_WIDTH-1:0] ifu_rd_addr,
  output logic [`DATA_WIDTH-1:0] ifu_rd_data,
  output logic                   ifu_rd_valid,
  input  logic                   exec_rd_req,
  input  logic [`ADDR_WIDTH-1:0] exec_rd_addr,
  output logic [`DATA_WIDTH-1:0] exec_rd_data,
  output logic                   exec_rd_valid,
  input  logic                   exec_wr_req,
  input  logic [`ADDR_WIDTH-1:0] exec_wr_addr,
  input  logic [`DATA_WIDTH-1:0] exec_wr_data,
  output logic                   exec_wr_done,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [`ADDR_WIDTH-1:0] mem_addr,
  output logic [`DATA_WIDTH-1:0] mem_wdata,
  input  logic [`DATA_WIDTH-1:0] mem_rdata,
  output logic                   arb_busy
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int LW = 3;

  arb_state_e             state;
  arb_state_e             state_nxt;
  arb_client_e            client;
  arb_client_e            client_nxt;
  arb_client_e            win;
  logic [LW-1:0]          lat_cnt;
  logic [LW-1:0]          lat_nxt;
  logic [SW-1:0]          starve_cnt;
  logic [SW-1:0]          starve_nxt;
  logic                   starved;
  logic                   any_req;
  logic                   mem_req_nxt;
  logic                   mem_we_nxt;
  logic [`ADDR_WIDTH-1:0] mem_addr_nxt;
  logic [`DATA_WIDTH-1:0] mem_wdata_nxt;
  logic [`DATA_WIDTH-1:0] ifu_data_nxt;
  logic [`DATA_WIDTH-1:0] exec_data_nxt;
  logic                   ifu_valid_nxt;
  logic                   exec_valid_nxt;
  logic                   wr_done_nxt;
  logic                   busy_nxt;

  assign starved = (starve_cnt == SW'(STARVE_LIMIT));
  assign any_req = ifu_rd_req | exec_rd_req | exec_wr_req;
  assign win     = arb_pick(exec_wr_req, exec_rd_req, ifu_rd_req, starved);

  always_comb begin
    state_nxt      = state;
    client_nxt     = client;
    lat_nxt        = lat_cnt;
    starve_nxt     = starve_cnt;
    mem_req_nxt    = 1'b0;
    mem_we_nxt     = 1'b0;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;
    ifu_data_nxt   = ifu_rd_data;
    exec_data_nxt  = exec_rd_data;
    ifu_valid_nxt  = 1'b0;
    exec_valid_nxt = 1'b0;
    wr_done_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt   = ISSUE;
          client_nxt  = win;
          mem_req_nxt = 1'b1;
          case (win)
            CL_EXWR: begin
              mem_we_nxt    = 1'b1;
              mem_addr_nxt  = exec_wr_addr;
              mem_wdata_nxt = exec_wr_data;
            end
            CL_EXRD: mem_addr_nxt = exec_rd_addr;
            default: mem_addr_nxt = ifu_rd_addr;
          endcase
          // Fetch loss is only counted when fetch was actually asking.
          if (win == CL_IFU) begin
            starve_nxt = '0;
          end else if (ifu_rd_req && !starved) begin
            starve_nxt = starve_cnt + SW'(1);
          end else begin
            starve_nxt = starve_cnt;
          end
        end else begin
          state_nxt = IDLE;
        end
      end

      ISSUE: begin
        if (client == CL_EXWR) begin
          state_nxt   = RESP;
          wr_done_nxt = 1'b1;
        end else begin
          state_nxt = WAIT;
          lat_nxt   = LW'(RD_LATENCY);
        end
      end

      // mem_rdata is valid in the last WAIT cycle; capture and flag together.
      WAIT: begin
        if (lat_cnt <= LW'(1)) begin
          state_nxt = RESP;
          lat_nxt   = '0;
          if (client == CL_EXRD) begin
            exec_data_nxt  = mem_rdata;
            exec_valid_nxt = 1'b1;
          end else begin
            ifu_data_nxt  = mem_rdata;
            ifu_valid_nxt = 1'b1;
          end
        end else begin
          lat_nxt = lat_cnt - LW'(1);
        end
      end

      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // State and every output register; reset discards any in-flight access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      client        <= CL_IFU;
      lat_cnt       <= '0;
      starve_cnt    <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      ifu_rd_data   <= '0;
      exec_rd_data  <= '0;
      ifu_rd_valid  <= 1'b0;
      exec_rd_valid <= 1'b0;
      exec_wr_done  <= 1'b0;
      arb_busy      <= 1'b0;
    end else begin
      state         <= state_nxt;
      client        <= client_nxt;
      lat_cnt       <= lat_nxt;
      starve_cnt    <= starve_nxt;
      mem_req       <= mem_req_nxt;
      mem_we        <= mem_we_nxt;
      mem_addr      <= mem_addr_nxt;
      mem_wdata     <= mem_wdata_nxt;
      ifu_rd_data   <= ifu_data_nxt;
      exec_rd_data  <= exec_data_nxt;
      ifu_rd_valid  <= ifu_valid_nxt;
      exec_rd_valid <= exec_valid_nxt;
      exec_wr_done  <= wr_done_nxt;
      arb_busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_pdp_mem_arbiter.sv
// Scoreboard bench for pdp_mem_arbiter: three instances (RD_LATENCY 1, 3, 4),
// each with its own latency-accurate memory model.
module tb_pdp_mem_arbiter;
  import pdp8_pkg::*;

  localparam int AW = `ADDR_WIDTH;
  localparam int DW = `DATA_WIDTH;
  localparam int NI = 3;

  typedef struct {
    int            cl;
    logic [DW-1:0] data;
    int            at;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  logic          ifu_rd_req    [NI];
  logic [AW-1:0] ifu_rd_addr   [NI];
  logic [DW-1:0] ifu_rd_data   [NI];
  logic          ifu_rd_valid  [NI];
  logic          exec_rd_req   [NI];
  logic [AW-1:0] exec_rd_addr  [NI];
  logic [DW-1:0] exec_rd_data  [NI];
  logic          exec_rd_valid [NI];
  logic          exec_wr_req   [NI];
  logic [AW-1:0] exec_wr_addr  [NI];
  logic [DW-1:0] exec_wr_data  [NI];
  logic          exec_wr_done  [NI];
  logic          mem_req       [NI];
  logic          mem_we        [NI];
  logic [AW-1:0] mem_addr      [NI];
  logic [DW-1:0] mem_wdata     [NI];
  logic [DW-1:0] mem_rdata     [NI];
  logic          arb_busy      [NI];

  logic          pl_en = 1'b0;
  int            pl_g = 0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : gen_dut
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    logic [DW-1:0] mem  [1<<AW];
    logic [DW-1:0] pipe [L];

    pdp_mem_arbiter #(.RD_LATENCY(L), .STARVE_LIMIT(8)) u_dut (
      .clk(clk), .reset(reset),
      .ifu_rd_req(ifu_rd_req[g]), .ifu_rd_addr(ifu_rd_addr[g]),
      .ifu_rd_data(ifu_rd_data[g]), .ifu_rd_valid(ifu_rd_valid[g]),
      .exec_rd_req(exec_rd_req[g]), .exec_rd_addr(exec_rd_addr[g]),
      .exec_rd_data(exec_rd_data[g]), .exec_rd_valid(exec_rd_valid[g]),
      .exec_wr_req(exec_wr_req[g]), .exec_wr_addr(exec_wr_addr[g]),
      .exec_wr_data(exec_wr_data[g]), .exec_wr_done(exec_wr_done[g]),
      .mem_req(mem_req[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .arb_busy(arb_busy[g])
    );

    // Synchronous memory: data for the address in the req cycle appears L cycles later.
    always @(posedge clk) begin
      if (pl_en && pl_g == g) mem[pl_addr] <= pl_data;
      else if (mem_req[g] && mem_we[g]) mem[mem_addr[g]] <= mem_wdata[g];
      pipe[0] <= mem[mem_addr[g]];
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata[g] = pipe[L-1];
  end

  function automatic logic [63:0] outs(input int g);
    return {mem_req[g], mem_we[g], mem_addr[g], mem_wdata[g], ifu_rd_valid[g],
            exec_rd_valid[g], exec_wr_done[g], ifu_rd_data[g], exec_rd_data[g], arb_busy[g]};
  endfunction

  task automatic preload(input int g, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pl_g = g; pl_addr = a; pl_data = d; pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic wait_memreq(input int g, input int budget, output logic [AW-1:0] a,
                             output logic we, output logic [DW-1:0] wd, output int at,
                             output bit to);
    to = 1'b1; a = '0; we = 1'b0; wd = '0; at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (mem_req[g] === 1'b1) begin
        a = mem_addr[g]; we = mem_we[g]; wd = mem_wdata[g]; at = cyc; to = 1'b0;
        break;
      end
    end
  endtask

  // Next completion pulse of any client; the client drops its request unless hold.
  task automatic wait_event(input int g, input int budget, input bit hold, output int cl,
                            output logic [DW-1:0] data, output int at, output bit to);
    to = 1'b1; cl = -1; data = '0; at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ifu_rd_valid[g] === 1'b1) begin
        cl = int'(CL_IFU); data = ifu_rd_data[g];
        if (!hold) ifu_rd_req[g] = 1'b0;
      end else if (exec_rd_valid[g] === 1'b1) begin
        cl = int'(CL_EXRD); data = exec_rd_data[g];
        if (!hold) exec_rd_req[g] = 1'b0;
      end else if (exec_wr_done[g] === 1'b1) begin
        cl = int'(CL_EXWR);
        if (!hold) exec_wr_req[g] = 1'b0;
      end
      if (cl >= 0) begin
        at = cyc; to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      total++;
      if (outs(g) !== 64'd0) begin
        bad++; $display("FAIL reset_outputs[%0d]: got %h, want 0", g, outs(g));
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_fetch_read();
    int r, at, cl; logic [AW-1:0] a; logic we; logic [DW-1:0] wd, d; bit to; exp_t e;
    preload(0, 12'o0200, 12'o7041);
    @(negedge clk);
    r = cyc; ifu_rd_addr[0] = 12'o0200; ifu_rd_req[0] = 1'b1;
    sb.push_back('{int'(CL_IFU), 12'o7041, r + 3});
    wait_memreq(0, 10, a, we, wd, at, to);
    total++;
    if (to || at !== r + 1 || a !== 12'o0200 || we !== 1'b0) begin
      bad++; $display("FAIL fetch_memreq: got at=%0d addr=%o we=%b, want at=%0d addr=0200 we=0", at, a, we, r + 1);
    end
    wait_event(0, 10, 1'b0, cl, d, at, to);
    e = sb.pop_front();
    total++;
    if (to || cl !== e.cl || d !== e.data || at !== e.at) begin
      bad++; $display("FAIL fetch_resp: got cl=%0d data=%o at=%0d, want cl=%0d data=%o at=%0d", cl, d, at, e.cl, e.data, e.at);
    end
    @(negedge clk);
    total++;
    if (ifu_rd_valid[0] !== 1'b0 || ifu_rd_data[0] !== 12'o7041) begin
      bad++; $display("FAIL fetch_pulse_hold: got valid=%b data=%o, want valid=0 data=7041", ifu_rd_valid[0], ifu_rd_data[0]);
    end
  endtask

  task automatic test_exec_write();
    int r, at, cl; logic [AW-1:0] a; logic we; logic [DW-1:0] wd, d; bit to; exp_t e;
    @(negedge clk);
    r = cyc; exec_wr_addr[0] = 12'o0050; exec_wr_data[0] = 12'o1234; exec_wr_req[0] = 1'b1;
    sb.push_back('{int'(CL_EXWR), '0, r + 2});
    wait_memreq(0, 10, a, we, wd, at, to);
    total++;
    if (to || at !== r + 1 || a !== 12'o0050 || we !== 1'b1 || wd !== 12'o1234) begin
      bad++; $display("FAIL write_memreq: got at=%0d addr=%o we=%b wdata=%o, want at=%0d 0050 1 1234", at, a, we, wd, r + 1);
    end
    wait_event(0, 10, 1'b0, cl, d, at, to);
    e = sb.pop_front();
    total++;
    if (to || cl !== e.cl || at !== e.at) begin
      bad++; $display("FAIL write_done: got cl=%0d at=%0d, want cl=%0d at=%0d", cl, at, e.cl, e.at);
    end
    @(negedge clk);
    r = cyc; exec_rd_addr[0] = 12'o0050; exec_rd_req[0] = 1'b1;
    sb.push_back('{int'(CL_EXRD), 12'o1234, r + 3});
    wait_event(0, 10, 1'b0, cl, d, at, to);
    e = sb.pop_front();
    total++;
    if (to || cl !== e.cl || d !== e.data || at !== e.at) begin
      bad++; $display("FAIL write_readback: got cl=%0d data=%o at=%0d, want cl=%0d data=%o at=%0d", cl, d, at, e.cl, e.data, e.at);
    end
  endtask

  task automatic test_contention();
    int r, at, cl; logic [DW-1:0] d; bit to; exp_t e;
    preload(0, 12'o0300, 12'o7777);
    preload(0, 12'o0400, 12'o2222);
    @(negedge clk);
    r = cyc;
    exec_wr_addr[0] = 12'o0300; exec_wr_data[0] = 12'o5555; exec_wr_req[0] = 1'b1;
    exec_rd_addr[0] = 12'o0300; exec_rd_req[0] = 1'b1;
    ifu_rd_addr[0]  = 12'o0400; ifu_rd_req[0]  = 1'b1;
    sb.push_back('{int'(CL_EXWR), '0, r + 2});
    sb.push_back('{int'(CL_EXRD), 12'o5555, r + 6});
    sb.push_back('{int'(CL_IFU), 12'o2222, r + 10});
    for (int k = 0; k < 3; k++) begin
      wait_event(0, 20, 1'b0, cl, d, at, to);
      e = sb.pop_front();
      total++;
      if (to || cl !== e.cl || at !== e.at || (cl != int'(CL_EXWR) && d !== e.data)) begin
        bad++; $display("FAIL contention_%0d: got cl=%0d data=%o at=%0d, want cl=%0d data=%o at=%0d", k, cl, d, at, e.cl, e.data, e.at);
      end
      if (k == 1) begin
        total++;
        if (int'(gen_dut[0].u_dut.starve_cnt) !== 2) begin
          bad++; $display("FAIL starve_before_grant: got %0d, want 2", gen_dut[0].u_dut.starve_cnt);
        end
      end
    end
    total++;
    if (int'(gen_dut[0].u_dut.starve_cnt) !== 0) begin
      bad++; $display("FAIL starve_after_grant: got %0d, want 0", gen_dut[0].u_dut.starve_cnt);
    end
  endtask

  task automatic test_starvation();
    int r, at, cl; logic [DW-1:0] d; bit to; exp_t e;
    preload(0, 12'o0600, 12'o0606);
    preload(0, 12'o0700, 12'o0707);
    @(negedge clk);
    r = cyc;
    exec_rd_addr[0] = 12'o0600; exec_rd_req[0] = 1'b1;
    ifu_rd_addr[0]  = 12'o0700; ifu_rd_req[0]  = 1'b1;
    for (int k = 0; k < 8; k++) sb.push_back('{int'(CL_EXRD), 12'o0606, r + 3 + 4 * k});
    sb.push_back('{int'(CL_IFU), 12'o0707, r + 35});
    for (int k = 0; k < 9; k++) begin
      wait_event(0, 20, 1'b1, cl, d, at, to);
      e = sb.pop_front();
      total++;
      if (to || cl !== e.cl || d !== e.data || at !== e.at) begin
        bad++; $display("FAIL starve_decision_%0d: got cl=%0d data=%o at=%0d, want cl=%0d data=%o at=%0d", k + 1, cl, d, at, e.cl, e.data, e.at);
      end
    end
    exec_rd_req[0] = 1'b0; ifu_rd_req[0] = 1'b0;
  endtask

  task automatic test_back_to_back();
    int r, at, cl; logic [DW-1:0] d; bit to; exp_t e;
    @(negedge clk);
    r = cyc; exec_wr_addr[0] = 12'o0060; exec_wr_data[0] = 12'o0001; exec_wr_req[0] = 1'b1;
    sb.push_back('{int'(CL_EXWR), '0, r + 2});
    sb.push_back('{int'(CL_EXWR), '0, r + 5});
    for (int k = 0; k < 2; k++) begin
      wait_event(0, 10, 1'b1, cl, d, at, to);
      e = sb.pop_front();
      total++;
      if (to || cl !== e.cl || at !== e.at) begin
        bad++; $display("FAIL b2b_write_%0d: got cl=%0d at=%0d, want cl=%0d at=%0d", k, cl, at, e.cl, e.at);
      end
      exec_wr_addr[0] = 12'o0061; exec_wr_data[0] = 12'o0002;
    end
    exec_wr_req[0] = 1'b0;
    @(negedge clk);
    total++;
    if (gen_dut[0].mem[12'o0060] !== 12'o0001 || gen_dut[0].mem[12'o0061] !== 12'o0002) begin
      bad++; $display("FAIL b2b_mem: got %o %o, want 0001 0002", gen_dut[0].mem[12'o0060], gen_dut[0].mem[12'o0061]);
    end
  endtask

  task automatic test_reset_mid_read();
    int r, rr, at, cl, mat; logic [AW-1:0] a; logic we; logic [DW-1:0] wd, d; bit to, seen; exp_t e;
    preload(1, 12'o0100, 12'o4321);
    @(negedge clk);
    r = cyc; ifu_rd_addr[1] = 12'o0100; ifu_rd_req[1] = 1'b1;
    wait_memreq(1, 8, a, we, wd, mat, to);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (to || arb_busy[1] !== 1'b1 || mat !== r + 1) begin
      bad++; $display("FAIL rst_pre_wait: got busy=%b req_at=%0d, want busy=1 req_at=%0d", arb_busy[1], mat, r + 1);
    end
    reset = 1'b1;
    #1;
    total++;
    if (outs(1) !== 64'd0) begin
      bad++; $display("FAIL rst_async_clear: got %h, want 0", outs(1));
    end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ifu_rd_valid[1] !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL rst_no_valid: got valid during reset, want none");
    end
    reset = 1'b0; rr = cyc;
    sb.push_back('{int'(CL_IFU), 12'o4321, rr + 5});
    wait_event(1, 20, 1'b0, cl, d, at, to);
    e = sb.pop_front();
    total++;
    if (to || cl !== e.cl || d !== e.data || at !== e.at) begin
      bad++; $display("FAIL rst_reserve: got cl=%0d data=%o at=%0d, want cl=%0d data=%o at=%0d", cl, d, at, e.cl, e.data, e.at);
    end
  endtask

  task automatic test_latency_sweep();
    int r, at, cl; logic [AW-1:0] a; logic we; logic [DW-1:0] wd, d; bit to; exp_t e;
    preload(2, 12'o0010, 12'o0777);
    @(negedge clk);
    r = cyc; ifu_rd_addr[2] = 12'o0010; ifu_rd_req[2] = 1'b1;
    sb.push_back('{int'(CL_IFU), 12'o0777, r + 6});
    wait_memreq(2, 10, a, we, wd, at, to);
    total++;
    if (to || at !== r + 1 || a !== 12'o0010) begin
      bad++; $display("FAIL lat4_memreq: got at=%0d addr=%o, want at=%0d addr=0010", at, a, r + 1);
    end
    wait_event(2, 20, 1'b0, cl, d, at, to);
    e = sb.pop_front();
    total++;
    if (to || cl !== e.cl || d !== e.data || at !== e.at) begin
      bad++; $display("FAIL lat4_resp: got cl=%0d data=%o at=%0d, want cl=%0d data=%o at=%0d", cl, d, at, e.cl, e.data, e.at);
    end
  endtask

  initial begin
    for (int g = 0; g < NI; g++) begin
      ifu_rd_req[g] = 1'b0;  ifu_rd_addr[g] = '0;
      exec_rd_req[g] = 1'b0; exec_rd_addr[g] = '0;
      exec_wr_req[g] = 1'b0; exec_wr_addr[g] = '0; exec_wr_data[g] = '0;
    end
    test_reset();
    test_fetch_read();
    test_exec_write();
    test_contention();
    test_starvation();
    test_back_to_back();
    test_reset_mid_read();
    test_latency_sweep();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
